// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO drain engine and its skid buffer.
package fifo_stream_pkg;
  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 3;

  typedef logic [DATA_W-1:0] byte_t;
  typedef logic [1:0]        occ_t;

  // Circular pointer advance over the BUF_DEPTH entries.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/fifo_rd_buf.sv
// Three-entry circular buffer that catches bytes landing from the FIFO's registered dout.
module fifo_rd_buf import fifo_stream_pkg::*; #(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output occ_t             occ
);
  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Head reads as zero when empty so stale entries never leak after a reset.
  assign head = (occ != 2'd0) ? mem[rd_ptr] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && !pop && occ == 2'(BUF_DEPTH)));
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the byte FIFO into a valid/ready stream, one beat per cycle, with packet framing.
module fifo_stream_reader import fifo_stream_pkg::*; #(
  parameter int DATA_W  = fifo_stream_pkg::DATA_W,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic              fifo_wr,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  pkt_count
);
  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic              rd_fire;
  logic              inflight;
  logic              pop;
  occ_t              occ;
  logic [DATA_W-1:0] head;
  logic [BEAT_W-1:0] beat;

  // Issue only when every byte already taken or in flight still has a slot;
  // the FIFO drops our read whenever it accepts a write in the same cycle.
  assign fifo_rd = ~rst & ~fifo_empty & ((3'(occ) + 3'(inflight)) <= 3'd2);
  assign rd_fire = fifo_rd & ~fifo_empty & ~(fifo_wr & ~fifo_full);

  // Stream handshake: a beat transfers on any edge where m_valid and m_ready are
  // both high; once raised, m_valid, m_data and m_last hold until that transfer.
  assign m_valid = (occ != 2'd0);
  assign m_data  = head;
  assign m_last  = m_valid & (beat == BEAT_W'(PKT_LEN - 1));
  assign pop     = m_valid & m_ready;

  fifo_rd_buf #(.WIDTH(DATA_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (fifo_dout),
    .pop     (pop),
    .head    (head),
    .occ     (occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight  <= 1'b0;
      beat      <= '0;
      pkt_count <= '0;
    end else begin
      inflight <= rd_fire;
      if (pop) begin
        if (beat == BEAT_W'(PKT_LEN - 1)) beat <= '0;
        else                              beat <= beat + 1'b1;
      end
      if (pop && m_last) pkt_count <= pkt_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, byte-order scoreboard and packet-count checks.
module tb_fifo_stream_reader;
  localparam int PKT_LEN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       fifo_empty, fifo_full, fifo_wr, fifo_rd;
  logic [7:0] fifo_dout = 8'h00;
  logic       m_valid, m_ready, m_last;
  logic [7:0] m_data;
  logic [15:0] pkt_count;
  logic [7:0] wr_data;
  logic       fifo_flush;

  logic       empty2, full2, wr2, ready2, rd2, valid2, last2;
  logic [7:0] dout2, data2;
  logic [1:0] cnt2;

  fifo_stream_reader #(.DATA_W(8), .PKT_LEN(PKT_LEN), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_wr(fifo_wr), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .pkt_count(pkt_count)
  );

  fifo_stream_reader #(.DATA_W(8), .PKT_LEN(1), .CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst), .fifo_empty(empty2), .fifo_full(full2),
    .fifo_wr(wr2), .fifo_dout(dout2), .fifo_rd(rd2),
    .m_valid(valid2), .m_ready(ready2), .m_data(data2), .m_last(last2),
    .pkt_count(cnt2)
  );

  // ---------------- behavioural 16-deep FIFO, write has priority ----------------
  logic [7:0] fmem [16];
  int fcount = 0, fw = 0, fr = 0;
  assign fifo_empty = (fcount == 0);
  assign fifo_full  = (fcount == 16);

  always @(posedge clk) begin
    if (fifo_flush) begin
      fcount <= 0; fw <= 0; fr <= 0;
    end else if (fifo_wr && fcount < 16) begin
      fmem[fw] <= wr_data; fw <= (fw + 1) % 16; fcount <= fcount + 1;
    end else if (fifo_rd && fcount > 0) begin
      fifo_dout <= fmem[fr]; fr <= (fr + 1) % 16; fcount <= fcount - 1;
    end
  end

  // ---------------- checking helpers ----------------
  int cmp_count = 0;
  int fail_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q [$];
  logic [7:0]  cap_data [$];
  logic        cap_last [$];
  logic [15:0] cap_cnt [$];
  int   taken = 0, pops = 0;
  logic prev_fire = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int   first_fire_cyc = -1, first_valid_cyc = -1;

  // Bytes taken from the FIFO minus bytes delivered is what the engine is holding.
  always @(negedge clk) begin : monitor
    logic fire, exp_rd;
    int held;
    held   = taken - pops;
    exp_rd = !rst && !fifo_empty && (held <= 2);
    check("fifo_rd_rule", fifo_rd, exp_rd);
    fire = fifo_rd && !fifo_empty && !(fifo_wr && !fifo_full);
    if (rst) begin
      taken = 0; pops = 0; prev_fire = 1'b0; prev_stall = 1'b0;
    end else begin
      check("m_valid_rule", m_valid, (held - int'(prev_fire)) > 0);
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("pop_without_data", 1, 0);
        else begin
          check("m_data", m_data, exp_q.pop_front());
          check("m_last", m_last, (pops % PKT_LEN) == PKT_LEN - 1);
          check("pkt_count", pkt_count, (pops / PKT_LEN) & 16'hFFFF);
        end
        cap_data.push_back(m_data);
        cap_last.push_back(m_last);
        cap_cnt.push_back(pkt_count);
        pops++;
      end
      if (fire) begin
        taken++;
        if (first_fire_cyc < 0) first_fire_cyc = cyc;
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      prev_fire  = fire;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
    if (fifo_wr && !fifo_full && !fifo_flush) exp_q.push_back(wr_data);
  end

  // ---------------- drivers ----------------
  task automatic reset_all();
    rst = 1'b1; fifo_flush = 1'b1; fifo_wr = 1'b0; m_ready = 1'b0; empty2 = 1'b1;
    step(); step();
    rst = 1'b0; fifo_flush = 1'b0;
    exp_q.delete(); cap_data.delete(); cap_last.delete(); cap_cnt.delete();
    first_fire_cyc = -1; first_valid_cyc = -1;
  endtask

  task automatic write_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_wr = 1'b1; wr_data = base + 8'(i);
      step();
    end
    fifo_wr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 400) begin
      step(); n++;
    end
    check(name, (n < 400), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_fifo_rd"},   fifo_rd,   0);
    check({tag, "_m_valid"},   m_valid,   0);
    check({tag, "_m_data"},    m_data,    0);
    check({tag, "_m_last"},    m_last,    0);
    check({tag, "_pkt_count"}, pkt_count, 0);
  endtask

  // ---------------- vector table for the basic stream ----------------
  typedef struct {
    logic [7:0]  din;
    logic [7:0]  exp_data;
    logic        exp_last;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t vec [8];

  logic writer_done;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int exp_wrap [5];
    int fires2, k;
    logic pend;
    exp_wrap = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 8; i++) begin
      vec[i].din      = 8'h10 + 8'(i);
      vec[i].exp_data = 8'h10 + 8'(i);
      vec[i].exp_last = (i % 4 == 3);
      vec[i].exp_cnt  = 16'(i / 4);
    end
    fifo_wr = 1'b0; wr_data = 8'h00; m_ready = 1'b0; fifo_flush = 1'b1;
    empty2 = 1'b1; full2 = 1'b0; wr2 = 1'b0; ready2 = 1'b1; dout2 = 8'h5A;

    // reset state
    step();
    @(negedge clk);
    check_outputs_zero("reset");
    reset_all();

    // basic stream
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fifo_wr = 1'b1; wr_data = vec[i].din;
      step();
    end
    fifo_wr = 1'b0;
    wait_drain("basic_drain");
    check("basic_beats", cap_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < cap_data.size()) begin
        check("basic_data", cap_data[i], vec[i].exp_data);
        check("basic_last", cap_last[i], vec[i].exp_last);
        check("basic_cnt",  cap_cnt[i],  vec[i].exp_cnt);
      end
    end
    check("basic_pkt_count", pkt_count, 2);
    check("basic_latency", first_valid_cyc - first_fire_cyc, 2);

    // backpressure
    reset_all();
    write_bytes(8'h80, 16);
    repeat (10) step();
    @(negedge clk);
    check("bp_fifo_rd", fifo_rd, 0);
    check("bp_m_valid", m_valid, 1);
    check("bp_m_data", m_data, 8'h80);
    check("bp_occ", u_dut.occ, 3);
    check("bp_fifo_count", fcount, 13);
    @(posedge clk); #1;
    begin
      int p0;
      p0 = pops;
      m_ready = 1'b1;
      repeat (16) step();
      check("bp_no_gaps", pops - p0, 16);
    end
    wait_drain("bp_drain");

    // write collision
    reset_all();
    m_ready = 1'b1;
    fifo_wr = 1'b1; wr_data = 8'h40;
    step();
    wr_data = 8'h41;
    @(negedge clk);
    check("coll_fifo_rd", fifo_rd, 1);
    @(posedge clk); #1;
    fifo_wr = 1'b0;
    @(negedge clk);
    check("coll_inflight", u_dut.inflight, 0);
    wait_drain("coll_drain");
    check("coll_beats", cap_data.size(), 2);

    // toggling ready over 32 bytes
    reset_all();
    writer_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          int n;
          n = 0;
          while (fifo_full && n < 100) begin step(); n++; end
          fifo_wr = 1'b1; wr_data = 8'($urandom);
          step();
          fifo_wr = 1'b0;
        end
        writer_done = 1'b1;
      end
      begin
        for (int c = 0; c < 600 && !(writer_done && exp_q.size() == 0 && !m_valid); c++) begin
          m_ready = (c % 2 == 0);
          step();
        end
      end
    join
    check("tog_all_delivered", exp_q.size(), 0);
    check("tog_beats", cap_data.size(), 32);
    check("tog_pkt_count", pkt_count, 8);

    // randomized traffic
    reset_all();
    for (int c = 0; c < 400; c++) begin
      fifo_wr = ($urandom_range(0, 99) < 55);
      wr_data = 8'($urandom);
      m_ready = ($urandom_range(0, 99) < 65);
      step();
    end
    fifo_wr = 1'b0; m_ready = 1'b1;
    wait_drain("rand_drain");
    check("rand_pkt_count", pkt_count, (pops / PKT_LEN) & 16'hFFFF);

    // mid-packet reset
    reset_all();
    write_bytes(8'hC0, 4);
    repeat (5) step();
    m_ready = 1'b1; step();
    m_ready = 1'b0; repeat (4) step();
    m_ready = 1'b1; step();
    m_ready = 1'b0;
    @(negedge clk);
    check("mid_occ", u_dut.occ, 2);
    check("mid_beats", pops, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    exp_q.delete(); cap_data.delete(); cap_last.delete(); cap_cnt.delete();
    @(posedge clk); #1;
    m_ready = 1'b1;
    write_bytes(8'hD0, 4);
    wait_drain("mid_drain");
    check("mid_new_beats", cap_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_last.size()) check("mid_new_last", cap_last[i], (i == 3));
    end

    // packet count wrap, PKT_LEN=1, CNT_W=2
    reset_all();
    empty2 = 1'b0;
    fires2 = 0; k = 0; pend = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pend && k < 5) begin
        check("wrap_pkt_count", cnt2, exp_wrap[k]);
        k++;
      end
      if (rd2 && !empty2) fires2++;
      pend = valid2;
      if (valid2) check("wrap_last", last2, 1);
      @(posedge clk); #1;
      empty2 = (fires2 >= 5);
    end
    check("wrap_beats", k, 5);
    check("wrap_final", cnt2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drain engine on the read side of the team's 16-deep synchronous byte FIFO. It issues FIFO reads, absorbs the FIFO's one-cycle registered `dout` latency in a 3-entry buffer, and presents bytes on a valid/ready stream. It sustains one byte per cycle and marks packet boundaries with `m_last`. It sits between the FIFO and any downstream byte consumer (serializer, checker, DMA).

## Interface
Parameters:
- `DATA_W`, 8, byte width; matches the FIFO `din`/`dout` width.
- `PKT_LEN`, 4, beats per packet; legal range 1..256.
- `CNT_W`, 16, width of `pkt_count`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_wr`  in  1  FIFO write strobe, observed only.
- `fifo_dout`  in  DATA_W  FIFO `dout`.
- `fifo_rd`  out  1  FIFO read strobe.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_W  stream byte.
- `m_last`  out  1  final beat of a packet.
- `pkt_count`  out  CNT_W  completed packets; wraps modulo 2^CNT_W.

## Operation
- **Read accept rule.** The FIFO gives write priority over read. A read is taken only when `rd_fire = fifo_rd & ~fifo_empty & ~(fifo_wr & ~fifo_full)`. A dropped read is not retried as a pending operation; `fifo_rd` is simply re-evaluated every cycle.
- **Issue condition.** `fifo_rd = ~rst & ~fifo_empty & (occ + inflight <= 2)`.
  - `occ` is the buffer occupancy, 0..3.
  - `inflight` is a 1-bit register, set to `rd_fire` each cycle.
  - `fifo_rd` depends on no combinational path from `m_ready`.
- **Buffer write.** When `inflight`=1, `fifo_dout` is written into the buffer at that edge.
- **Pop.** `pop = m_valid & m_ready`.
- **Occupancy update.** `occ` next = `occ + inflight - pop`. A write and a pop in the same cycle leave `occ` unchanged.
- **Overflow.** The issue rule guarantees `occ` never exceeds 3. Overflow is an assertion failure.
- **Output.** `m_valid = (occ != 0)`. `m_data` is the oldest entry, in FIFO order.
- **Stability.** While `m_valid & ~m_ready`, `m_data` and `m_last` hold stable.
- **Beat counter.** `beat` counts 0..PKT_LEN-1 and advances on `pop`, wrapping to 0.
  - `m_last = m_valid & (beat == PKT_LEN-1)`.
  - When `PKT_LEN`=1, `m_last = m_valid`.
- **Packet counter.** `pkt_count` increments on `pop & m_last`.
- **Reset values.** `fifo_rd`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `pkt_count`=0. `occ`, `inflight` and `beat` are also reset to 0.
- **Reset mid-operation.** Buffered and in-flight bytes are discarded; the bytes actually taken from the FIFO are lost. A partial packet is abandoned, and the next packet starts at `beat` 0. `rst` has priority over every other update in the same cycle.

## Timing
- **Latency.** Fire edge at cycle N → `fifo_dout` valid in N+1 → buffer write at the N+1 edge → `m_valid`=1 in N+2.
- **Throughput.** With `m_ready` held high and the FIFO non-empty, there is one beat per cycle after the two-cycle fill.
- **Stall.** Drop `m_ready` with stream running: at most one further fire and one in-flight landing, then `occ`=3 and `fifo_rd`=0.
- **Resume.** After `m_ready` returns, `fifo_rd` re-asserts on the cycle after `occ + inflight` falls to 2 or below. There are no bubbles on `m_valid` while `occ` > 0.
- **Empty FIFO.** `fifo_rd`=0. `m_valid` drops the cycle after the last buffered byte pops.
- **Simultaneous write and read.** If `fifo_wr` is accepted in the same cycle, the read does not fire, `inflight` stays 0, and no byte is buffered.

## Structure
- **Package `fifo_stream_pkg`:**
  - `DATA_W` default.
  - `localparam BUF_DEPTH = 3`.
  - `typedef logic [DATA_W-1:0] byte_t`.
  - `typedef logic [1:0] occ_t`.
- **Sub-module `fifo_rd_buf`:** the 3-entry circular buffer, with write-enable/data in, pop in, head data and occ out. The top level holds the issue logic, `inflight`, `beat` and `pkt_count`.

## Test plan
- **Basic stream.** Write 0x10..0x17 into the FIFO with `m_ready`=1. Expect 0x10..0x17 in order, with `m_last` on 0x13 and 0x17, `pkt_count`=2, and first `m_valid` two cycles after the first fire.
- **Backpressure.** Prefill 16 bytes and hold `m_ready`=0 for 10 cycles. Expect `occ`=3, `fifo_rd`=0, `m_data` stable, and the FIFO at count 13. Releasing `m_ready` yields 16 beats in order with no gaps.
- **Write collision.** Assert `fifo_wr` with FIFO not full on the cycle `fifo_rd`=1. Expect no fire, `inflight`=0, and no duplicated or skipped byte in the output.
- **Toggling ready.** Drive `m_ready` 1,0,1,0 over 32 bytes. Expect every byte exactly once and `pkt_count`=8.
- **Mid-packet reset.** Assert `rst` after 2 beats of a packet with `occ`=2. Next cycle expect all outputs 0. A new 4-byte stream restarts `m_last` at its 4th beat.
- **Packet count wrap.** With `PKT_LEN`=1 and `CNT_W`=2, send 5 beats. Expect `pkt_count` to read 1,2,3,0,1.
